// File: rtl/alarm_bank.sv
// Multi-channel alarm unit: programmable hh:mm alarms matched on minute ticks,
// with a shared ringing FSM supporting snooze, snooze limit, auto-timeout and a pending queue.
module alarm_bank #(
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_MIN       = 5,
  parameter int MAX_SNOOZE       = 3,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int IDW              = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int SCW             = ($clog2(MAX_SNOOZE + 1) < 2) ? 2 : $clog2(MAX_SNOOZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            cur_hr,
  input  logic [5:0]            cur_min,
  input  logic                  min_tick,
  input  logic                  wr_en,
  input  logic [IDW-1:0]        wr_sel,
  input  logic [4:0]            wr_hr,
  input  logic [5:0]            wr_min,
  input  logic                  wr_arm,
  input  logic                  snooze,
  input  logic                  stop,
  output logic                  ringing,
  output logic [IDW-1:0]        ring_id,
  output logic [NUM_ALARMS-1:0] armed,
  output logic [4:0]            rd_hr,
  output logic [5:0]            rd_min,
  output logic [SCW-1:0]        snooze_left
);

  typedef enum logic {IDLE, RING} state_t;
  state_t state, state_n;

  logic [4:0]            prog_hr [NUM_ALARMS];
  logic [5:0]            prog_min[NUM_ALARMS];
  logic [4:0]            tgt_hr  [NUM_ALARMS];
  logic [5:0]            tgt_min [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] pending;
  logic [SCW-1:0]        snz_cnt;
  logic [5:0]            to_cnt;

  logic           wr_ok, any_pend, tick_to;
  logic [4:0]     wr_hr_adj, snz_hr;
  logic [5:0]     snz_min;
  logic [6:0]     sum_min;
  logic [IDW-1:0] pick_idx;
  logic           start, end_stop, end_snz, end_wr;

  assign wr_ok     = wr_en && (wr_min < 6'd60) && (32'(wr_sel) < NUM_ALARMS);
  assign wr_hr_adj = (wr_hr >= 5'd24) ? wr_hr - 5'd24 : wr_hr;
  assign tick_to   = min_tick && (to_cnt == 6'(RING_TIMEOUT_MIN - 1));
  assign ringing     = (state == RING);
  assign snooze_left = SCW'(MAX_SNOOZE) - snz_cnt;

  always_comb begin
    rd_hr  = '0;
    rd_min = '0;
    if (32'(wr_sel) < NUM_ALARMS) begin
      rd_hr  = prog_hr[wr_sel];
      rd_min = prog_min[wr_sel];
    end
  end

  always_comb begin
    any_pend = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (pending[i] && !any_pend) begin
        any_pend = 1'b1;
        pick_idx = IDW'(i);
      end
    end
  end

  always_comb begin
    sum_min = {1'b0, tgt_min[ring_id]} + 7'(SNOOZE_MIN);
    snz_hr  = tgt_hr[ring_id];
    if (sum_min >= 7'd60) begin
      sum_min = sum_min - 7'd60;
      snz_hr  = (snz_hr == 5'd23) ? 5'd0 : snz_hr + 5'd1;
    end
    snz_min = sum_min[5:0];
  end

  // Priority while ringing: rewrite of the ringing channel, then stop/timeout, then snooze.
  always_comb begin
    state_n  = state;
    start    = 1'b0;
    end_stop = 1'b0;
    end_snz  = 1'b0;
    end_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (any_pend) begin
          state_n = RING;
          start   = 1'b1;
        end
      end
      RING: begin
        if (wr_ok && wr_sel == ring_id) begin
          state_n = IDLE;
          end_wr  = 1'b1;
        end else if (stop || tick_to) begin
          state_n  = IDLE;
          end_stop = 1'b1;
        end else if (snooze && snz_cnt < SCW'(MAX_SNOOZE)) begin
          state_n = IDLE;
          end_snz = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        prog_hr[i]  <= '0;
        prog_min[i] <= '0;
        tgt_hr[i]   <= '0;
        tgt_min[i]  <= '0;
      end
      armed   <= '0;
      pending <= '0;
      ring_id <= '0;
      snz_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        if (IDW'(i) == ring_id && end_stop) begin
          tgt_hr[i]  <= prog_hr[i];
          tgt_min[i] <= prog_min[i];
        end
        if (IDW'(i) == ring_id && end_snz) begin
          tgt_hr[i]  <= snz_hr;
          tgt_min[i] <= snz_min;
        end
        // Clear-on-pick precedes match-set so a fresh match is never lost.
        if (start && IDW'(i) == pick_idx) pending[i] <= 1'b0;
        if (min_tick && armed[i] && tgt_hr[i] == cur_hr && tgt_min[i] == cur_min)
          pending[i] <= 1'b1;
        if (wr_ok && IDW'(i) == wr_sel) begin
          prog_hr[i]  <= wr_hr_adj;
          prog_min[i] <= wr_min;
          tgt_hr[i]   <= wr_hr_adj;
          tgt_min[i]  <= wr_min;
          armed[i]    <= wr_arm;
          pending[i]  <= 1'b0;
        end
      end
      if (start) begin
        ring_id <= pick_idx;
        to_cnt  <= '0;
        if (tgt_hr[pick_idx] == prog_hr[pick_idx] && tgt_min[pick_idx] == prog_min[pick_idx])
          snz_cnt <= '0;
      end else if (state == RING && min_tick) begin
        to_cnt <= to_cnt + 6'd1;
      end
      if (end_snz) snz_cnt <= snz_cnt + SCW'(1);
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed scenarios plus a randomized phase,
// all compared against a minutes-of-day reference model.
module tb_alarm_bank;
  localparam int N    = 4;
  localparam int SNZ  = 5;
  localparam int MAXS = 3;
  localparam int TO   = 10;
  localparam int IDW  = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4:0]     cur_hr;
  logic [5:0]     cur_min;
  logic           min_tick, wr_en, wr_arm, snooze, stop;
  logic [IDW-1:0] wr_sel;
  logic [4:0]     wr_hr;
  logic [5:0]     wr_min;
  logic           ringing;
  logic [IDW-1:0] ring_id;
  logic [N-1:0]   armed;
  logic [4:0]     rd_hr;
  logic [5:0]     rd_min;
  logic [1:0]     snooze_left;

  alarm_bank #(.NUM_ALARMS(N), .SNOOZE_MIN(SNZ), .MAX_SNOOZE(MAXS), .RING_TIMEOUT_MIN(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cur_hr(cur_hr), .cur_min(cur_min), .min_tick(min_tick),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_hr(wr_hr), .wr_min(wr_min), .wr_arm(wr_arm),
    .snooze(snooze), .stop(stop), .ringing(ringing), .ring_id(ring_id), .armed(armed),
    .rd_hr(rd_hr), .rd_min(rd_min), .snooze_left(snooze_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: times held as minutes of the day.
  int m_prog[N], m_tgt[N];
  bit m_arm[N], m_pend[N];
  bit m_ring;
  int m_id, m_snz, m_to;
  int n_prog[N], n_tgt[N];
  bit n_arm[N], n_pend[N];
  bit n_ring;
  int n_id, n_snz, n_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] arm_mask();
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = m_arm[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prog[i] = 0; m_tgt[i] = 0; m_arm[i] = 0; m_pend[i] = 0;
    end
    m_ring = 0; m_id = 0; m_snz = 0; m_to = 0;
  endtask

  task automatic model_next();
    bit wok;
    int wt, now, p;
    wok = wr_en && (wr_min < 60);
    wt  = ((wr_hr >= 24) ? int'(wr_hr) - 24 : int'(wr_hr)) * 60 + int'(wr_min);
    now = int'(cur_hr) * 60 + int'(cur_min);
    n_prog = m_prog; n_tgt = m_tgt; n_arm = m_arm; n_pend = m_pend;
    n_ring = m_ring; n_id = m_id; n_snz = m_snz; n_to = m_to;
    if (!m_ring) begin
      p = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) p = i;
      if (p >= 0) begin
        n_ring = 1; n_id = p; n_pend[p] = 0; n_to = 0;
        if (m_tgt[p] == m_prog[p]) n_snz = 0;
      end
    end else begin
      if (min_tick) n_to = m_to + 1;
      if (wok && int'(wr_sel) == m_id) n_ring = 0;
      else if (stop || (min_tick && m_to + 1 == TO)) begin
        n_ring = 0; n_tgt[m_id] = m_prog[m_id];
      end else if (snooze && m_snz < MAXS) begin
        n_ring = 0; n_tgt[m_id] = (m_tgt[m_id] + SNZ) % 1440; n_snz = m_snz + 1;
      end
    end
    if (min_tick)
      for (int i = 0; i < N; i++) if (m_arm[i] && m_tgt[i] == now) n_pend[i] = 1;
    if (wok) begin
      n_prog[wr_sel] = wt; n_tgt[wr_sel] = wt; n_arm[wr_sel] = wr_arm; n_pend[wr_sel] = 0;
    end
  endtask

  task automatic check_all();
    chk("ringing", 32'(ringing), 32'(m_ring));
    chk("ring_id", 32'(ring_id), 32'(m_id));
    chk("armed", 32'(armed), arm_mask());
    chk("snooze_left", 32'(snooze_left), 32'(MAXS - m_snz));
    chk("rd_hr", 32'(rd_hr), 32'(m_prog[wr_sel] / 60));
    chk("rd_min", 32'(rd_min), 32'(m_prog[wr_sel] % 60));
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    m_prog = n_prog; m_tgt = n_tgt; m_arm = n_arm; m_pend = n_pend;
    m_ring = n_ring; m_id = n_id; m_snz = n_snz; m_to = n_to;
    check_all();
    min_tick = 0; wr_en = 0; snooze = 0; stop = 0;
  endtask

  task automatic wr(input int ch, input int h, input int m, input bit arm);
    wr_en = 1; wr_sel = IDW'(ch); wr_hr = 5'(h); wr_min = 6'(m); wr_arm = arm;
    step();
  endtask

  task automatic tick(input int h, input int m);
    cur_hr = 5'(h); cur_min = 6'(m); min_tick = 1;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press_stop();
    stop = 1; step();
  endtask

  task automatic press_snooze();
    snooze = 1; step();
  endtask

  initial begin
    int wall, r;
    rst_n = 0; cur_hr = 0; cur_min = 0; min_tick = 0; wr_en = 0; wr_sel = 0;
    wr_hr = 0; wr_min = 0; wr_arm = 0; snooze = 0; stop = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    #2 rst_n = 1;

    // Basic ring, 2-cycle latency, stop keeps programmed time
    wr(0, 6, 30, 1);
    tick(6, 29);
    tick(6, 30);
    chk("lat_cycle1", 32'(ringing), 32'd0);
    idle(1);
    chk("lat_cycle2", 32'(ringing), 32'd1);
    press_stop();
    wr_sel = 0; #1;
    chk("stop_rd_hr", 32'(rd_hr), 32'd6);
    chk("stop_rd_min", 32'(rd_min), 32'd30);

    // Snooze with midnight wrap, snooze limit, then timeout and reload
    wr(1, 23, 58, 1);
    tick(23, 58); idle(1);
    press_snooze();
    tick(0, 3); idle(1);
    chk("snz_wrap_ring", 32'(ringing), 32'd1);
    chk("snz_left_2", 32'(snooze_left), 32'd2);
    press_snooze();
    tick(0, 8); idle(1);
    press_snooze();
    tick(0, 13); idle(1);
    chk("snz_left_0", 32'(snooze_left), 32'd0);
    press_snooze();
    chk("snz_limit_ignored", 32'(ringing), 32'd1);
    for (int k = 0; k < TO; k++) tick(0, 14 + k);
    chk("timeout", 32'(ringing), 32'd0);
    tick(23, 58); idle(1);
    chk("reload_ring", 32'(ringing), 32'd1);
    press_stop();

    // Coincident alarms and mid-ring queueing
    wr(2, 7, 0, 1);
    wr(3, 7, 0, 1);
    tick(7, 0); idle(1);
    chk("coinc_first", 32'(ring_id), 32'd2);
    press_stop(); idle(1);
    chk("coinc_second", 32'(ring_id), 32'd3);
    tick(6, 30);
    press_stop(); idle(1);
    chk("queued_ch0", 32'(ring_id), 32'd0);
    press_stop();

    // Hour wrap on write, invalid minute, rewrite of the ringing channel
    wr(0, 25, 10, 1);
    chk("hr_wrap_rd", 32'(rd_hr), 32'd1);
    wr(0, 4, 60, 1);
    chk("min60_ignored", 32'(rd_min), 32'd10);
    tick(1, 10); idle(1);
    wr(0, 1, 10, 0);
    chk("disarm_stops", 32'(ringing), 32'd0);
    chk("disarm_armed", 32'(armed[0]), 32'd0);

    // Asynchronous reset mid-ring
    wr(2, 9, 0, 1);
    tick(9, 0); idle(1);
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    chk("async_ringing", 32'(ringing), 32'd0);
    #3 rst_n = 1;

    // Randomized traffic around a moving wall clock
    wall = 5 * 60 + 55;
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15) begin
        wr_en = 1; wr_sel = IDW'($urandom_range(0, N - 1)); wr_arm = 1'($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
          wr_hr = 5'($urandom_range(0, 31)); wr_min = 6'($urandom_range(0, 63));
        end else begin
          r = (wall + int'($urandom_range(0, 8))) % 1440;
          wr_hr = 5'(r / 60 + (($urandom_range(0, 5) == 0 && r < 480) ? 24 : 0));
          wr_min = 6'(r % 60);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        wall = (wall + 1) % 1440;
        cur_hr = 5'(wall / 60); cur_min = 6'(wall % 60); min_tick = 1;
      end
      if ($urandom_range(0, 5) == 0) snooze = 1;
      if ($urandom_range(0, 7) == 0) stop = 1;
      if (!wr_en) wr_sel = IDW'($urandom_range(0, N - 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
